// File: rtl/encoder_readout_sched_pkg.sv
// Shared types and constants for the encoder readout frame scheduler.
package encoder_readout_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNAP,
      ST_HDR,
      ST_POS,
      ST_VEL,
      ST_CSUM
   } state_t;

   localparam logic [15:0] HDR_WORD     = 16'hA55A;
   localparam int          N_CH_DEFAULT = 7;
   localparam int          FRAME_LEN    = 2 * N_CH_DEFAULT + 3;

   function automatic int frame_len(input int n_ch);
      return 2 * n_ch + 3;
   endfunction

endpackage

// File: rtl/encoder_readout_sched_if.sv
// Word stream carrying readout frames from the scheduler to its consumer.
interface encoder_readout_sched_if #(
   parameter int W = 16
) ();
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/encoder_readout_sched_snap_timer.sv
// Free-running snapshot interval timer; period 0 parks the counter at zero.
module snap_timer (
   input  logic        clk_encoder,
   input  logic        rst,
   input  logic [15:0] i_period,
   output logic        o_tick
);
   logic [15:0] r_cnt;

   // A shrinking period that lands below the count fires on the next cycle.
   assign o_tick = (i_period != 16'd0) && (r_cnt >= i_period - 16'd1);

   always_ff @(posedge clk_encoder) begin
      if (rst) begin
         r_cnt <= 16'd0;
      end else if (o_tick || (i_period == 16'd0)) begin
         r_cnt <= 16'd0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end
endmodule

// File: rtl/encoder_readout_sched.sv
// Snapshots encoder counts on request or timer tick and streams a framed
// readout: header, sequence, positions, velocities, checksum.
//
// state   | meaning
// IDLE    | waiting for a trigger
// SNAP    | capturing enc_pos, computing velocities
// HDR     | presenting header and sequence words
// POS     | presenting snapshot positions
// VEL     | presenting velocities
// CSUM    | presenting checksum (out_last)
module encoder_readout_sched
   import encoder_readout_sched_pkg::*;
#(
   parameter int           N_CH = N_CH_DEFAULT,
   parameter int           W    = 16,
   parameter logic [W-1:0] HDR  = W'(HDR_WORD)
) (
   input  logic                  clk_encoder,
   input  logic                  rst,
   input  logic [N_CH*W-1:0]     i_enc_pos,
   input  logic [15:0]           i_period,
   input  logic                  i_req,
   input  logic                  i_clr_ovr,
   encoder_readout_sched_if.master o_str,
   output logic                  o_busy,
   output logic                  o_overrun,
   output logic [7:0]            o_seq
);
   localparam int FLEN = frame_len(N_CH);
   localparam int IW   = $clog2(FLEN + 1);

   state_t        r_state;
   logic [IW-1:0] r_idx;
   logic [W-1:0]  r_snap [N_CH];
   logic [W-1:0]  r_prev [N_CH];
   logic [W-1:0]  r_vel  [N_CH];
   logic [W-1:0]  r_csum;
   logic [W-1:0]  r_data;
   logic          r_valid;
   logic          r_last;
   logic [7:0]    r_seq;
   logic          r_overrun;

   logic          w_tick;
   logic          w_trig;
   logic          w_drop;
   logic          w_xfer;
   logic [IW-1:0] w_nidx;
   logic [W-1:0]  w_sum;
   logic [W-1:0]  w_next;
   logic          w_nlast;
   state_t        w_nstate;

   snap_timer u_timer (
      .clk_encoder (clk_encoder),
      .rst         (rst),
      .i_period    (i_period),
      .o_tick      (w_tick)
   );

   assign w_trig = i_req | w_tick;
   assign w_drop = w_trig & (r_state != ST_IDLE);
   assign w_xfer = r_valid & o_str.out_ready;

   // Word following the one being accepted; the checksum slot takes the
   // running sum including the word leaving now.
   always_comb begin
      w_nidx   = r_idx + 1'b1;
      w_sum    = r_csum + r_data;
      w_next   = w_sum;
      w_nlast  = (int'(w_nidx) == FLEN - 1);
      w_nstate = ST_CSUM;
      if (int'(w_nidx) <= 1) begin
         w_next   = W'(r_seq);
         w_nstate = ST_HDR;
      end else if (int'(w_nidx) < N_CH + 2) begin
         w_nstate = ST_POS;
      end else if (int'(w_nidx) < 2 * N_CH + 2) begin
         w_nstate = ST_VEL;
      end
      for (int k = 0; k < N_CH; k++) begin
         if (int'(w_nidx) == k + 2)        w_next = r_snap[k];
         if (int'(w_nidx) == N_CH + k + 2) w_next = r_vel[k];
      end
   end

   always_ff @(posedge clk_encoder) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_csum    <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_seq     <= 8'd0;
         r_overrun <= 1'b0;
         for (int k = 0; k < N_CH; k++) begin
            r_snap[k] <= '0;
            r_prev[k] <= '0;
            r_vel[k]  <= '0;
         end
      end else begin
         r_overrun <= w_drop | (r_overrun & ~i_clr_ovr);
         case (r_state)
            ST_IDLE: begin
               if (w_trig) r_state <= ST_SNAP;
            end
            ST_SNAP: begin
               for (int k = 0; k < N_CH; k++) begin
                  r_snap[k] <= i_enc_pos[k*W +: W];
                  r_vel[k]  <= i_enc_pos[k*W +: W] - r_prev[k];
                  r_prev[k] <= i_enc_pos[k*W +: W];
               end
               r_state <= ST_HDR;
               r_idx   <= '0;
               r_csum  <= '0;
               r_data  <= HDR;
               r_valid <= 1'b1;
               r_last  <= 1'b0;
            end
            ST_CSUM: begin
               if (w_xfer) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_seq   <= r_seq + 8'd1;
               end
            end
            default: begin
               if (w_xfer) begin
                  r_idx   <= w_nidx;
                  r_data  <= w_next;
                  r_csum  <= w_sum;
                  r_last  <= w_nlast;
                  r_state <= w_nstate;
               end
            end
         endcase
      end
   end

   assign o_str.out_data  = r_data;
   assign o_str.out_valid = r_valid;
   assign o_str.out_last  = r_last;
   assign o_busy          = (r_state != ST_IDLE);
   assign o_overrun       = r_overrun;
   assign o_seq           = r_seq;
endmodule

// File: tb/tb_encoder_readout_sched.sv
// Scoreboard bench: a frame-level model predicts words and status, a monitor
// on the falling edge compares what the scheduler presents.
module tb_encoder_readout_sched;
   import encoder_readout_sched_pkg::*;

   localparam int N_CH = 7;
   localparam int W    = 16;
   localparam int P_IDLE = 0, P_SNAP = 1, P_PRES = 2;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
   } word_t;

   logic              clk_encoder = 1'b0;
   logic              rst    = 1'b1;
   logic [N_CH*W-1:0] enc_pos = '0;
   logic [15:0]       period = 16'd0;
   logic              req    = 1'b0;
   logic              clr    = 1'b0;
   logic              ready  = 1'b0;
   logic              busy;
   logic              ovr;
   logic [7:0]        seq;

   int checks = 0;
   int errors = 0;

   encoder_readout_sched_if #(.W(W)) bus ();
   assign bus.out_ready = ready;

   encoder_readout_sched #(.N_CH(N_CH), .W(W), .HDR(16'hA55A)) dut (
      .clk_encoder (clk_encoder),
      .rst         (rst),
      .i_enc_pos   (enc_pos),
      .i_period    (period),
      .i_req       (req),
      .i_clr_ovr   (clr),
      .o_str       (bus),
      .o_busy      (busy),
      .o_overrun   (ovr),
      .o_seq       (seq)
   );

   always #5 clk_encoder = ~clk_encoder;

   // Reference model state: phase of the frame and words still to be accepted.
   word_t      exp_q[$];
   int         m_cnt   = 0;
   int         m_phase = P_IDLE;
   int         m_left  = 0;
   logic [7:0] m_seq   = 8'd0;
   bit         m_ovr   = 1'b0;
   logic [W-1:0] m_prev [N_CH];

   initial for (int k = 0; k < N_CH; k++) m_prev[k] = '0;

   always @(posedge clk_encoder) begin
      bit tick, trig, drop;
      logic [W-1:0] pos, vel, sum;
      if (rst) begin
         m_cnt = 0; m_phase = P_IDLE; m_left = 0; m_seq = 8'd0; m_ovr = 1'b0;
         for (int k = 0; k < N_CH; k++) m_prev[k] = '0;
         exp_q.delete();
      end else begin
         tick = (period != 0) && (m_cnt >= int'(period) - 1);
         m_cnt = (tick || period == 0) ? 0 : m_cnt + 1;
         trig = req || tick;
         drop = trig && (m_phase != P_IDLE);
         case (m_phase)
            P_IDLE: if (trig) m_phase = P_SNAP;
            P_SNAP: begin
               sum = 16'hA55A + W'(m_seq);
               exp_q.push_back('{16'hA55A, 1'b0});
               exp_q.push_back('{W'(m_seq), 1'b0});
               for (int k = 0; k < N_CH; k++) begin
                  pos = enc_pos[k*W +: W];
                  exp_q.push_back('{pos, 1'b0});
                  sum = sum + pos;
               end
               for (int k = 0; k < N_CH; k++) begin
                  pos = enc_pos[k*W +: W];
                  vel = pos - m_prev[k];
                  m_prev[k] = pos;
                  exp_q.push_back('{vel, 1'b0});
                  sum = sum + vel;
               end
               exp_q.push_back('{sum, 1'b1});
               m_phase = P_PRES;
               m_left  = FRAME_LEN;
            end
            default: if (ready) begin
               m_left--;
               if (m_left == 0) begin
                  m_seq++;
                  m_phase = P_IDLE;
               end
            end
         endcase
         m_ovr = drop || (m_ovr && !clr);
      end
   end

   // Monitor: status every cycle, hold-while-stalled, and word scoreboard.
   bit           stalled = 1'b0;
   logic [W-1:0] st_d;
   logic         st_l;
   int           cyc = 0;

   always @(negedge clk_encoder) begin
      logic [11:0] got_s, exp_s;
      word_t w;
      cyc++;
      if (rst) begin
         stalled = 1'b0;
      end else begin
         exp_s = {m_phase == P_PRES, (m_phase == P_PRES) && (m_left == 1),
                  m_phase != P_IDLE, m_ovr, m_seq};
         got_s = {bus.out_valid, bus.out_last, busy, ovr, seq};
         checks++;
         if (got_s !== exp_s) begin
            errors++;
            $display("FAIL status cyc=%0d got v,l,busy,ovr,seq=%b exp %b", cyc, got_s, exp_s);
         end
         if (stalled && bus.out_valid) begin
            checks++;
            if ({bus.out_data, bus.out_last} !== {st_d, st_l}) begin
               errors++;
               $display("FAIL stall_hold cyc=%0d got %h/%b exp %h/%b", cyc, bus.out_data, bus.out_last, st_d, st_l);
            end
         end
         if (bus.out_valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word cyc=%0d got %h", cyc, bus.out_data);
            end else begin
               w = exp_q.pop_front();
               if ({bus.out_data, bus.out_last} !== {w.d, w.l}) begin
                  errors++;
                  $display("FAIL word cyc=%0d got %h/%b exp %h/%b", cyc, bus.out_data, bus.out_last, w.d, w.l);
               end
            end
         end
         stalled = bus.out_valid && !ready;
         st_d = bus.out_data;
         st_l = bus.out_last;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk_encoder);
         #1;
      end
   endtask

   task automatic pulse_req();
      req = 1'b1; step(); req = 1'b0;
   endtask

   initial begin
      int b;
      rst = 1'b1; step(3); rst = 1'b0; ready = 1'b1;

      // Counts 1..7, then channel 0 wrapping FFFF -> 0000
      for (int k = 0; k < N_CH; k++) enc_pos[k*W +: W] = W'(k + 1);
      pulse_req(); step(25);
      enc_pos[0 +: W] = 16'hFFFF; pulse_req(); step(25);
      enc_pos[0 +: W] = 16'h0000; pulse_req(); step(25);

      // Consumer toggling ready every cycle
      for (int i = 0; i < 45; i++) begin
         ready = (i % 2 == 0);
         req   = (i == 0);
         step();
      end
      req = 1'b0; ready = 1'b1; step(5);

      // Overrun while stalled, clear racing a drop, then a clean clear
      ready = 1'b0; pulse_req(); step(4); pulse_req(); step(3);
      clr = 1'b1; req = 1'b1; step(); clr = 1'b0; req = 1'b0; step(2);
      clr = 1'b1; step(); clr = 1'b0; ready = 1'b1; step(25);

      // req coinciding with the first timer tick after reset
      rst = 1'b1; period = 16'd10; step(2); rst = 1'b0;
      step(9); req = 1'b1; step(); req = 1'b0; period = 16'd0; step(25);

      // Reset while word 5 is presented, then a fresh frame
      pulse_req();
      b = 0;
      while (!(m_phase == P_PRES && m_left == FRAME_LEN - 4) && b < 100) begin
         step(); b++;
      end
      checks++;
      if (b >= 100) begin
         errors++;
         $display("FAIL wait_word5 waited %0d cycles, limit 100", b);
      end
      rst = 1'b1; step(); rst = 1'b0; step(3);
      for (int k = 0; k < N_CH; k++) enc_pos[k*W +: W] = W'($urandom);
      pulse_req(); step(25);

      // Periodic snapshots at 100 cycles
      rst = 1'b1; period = 16'd100; step(2); rst = 1'b0; step(350);
      period = 16'd0; step(25);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         for (int k = 0; k < N_CH; k++) enc_pos[k*W +: W] = W'($urandom);
         ready = ($urandom_range(0, 3) != 0);
         req   = ($urandom_range(0, 30) == 0);
         clr   = ($urandom_range(0, 40) == 0);
         rst   = ($urandom_range(0, 700) == 0);
         if ($urandom_range(0, 199) == 0) period = 16'($urandom_range(0, 40));
         step();
      end
      rst = 1'b0; req = 1'b0; clr = 1'b0; period = 16'd0; ready = 1'b1;
      step(60);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain words_left=%0d exp 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
